// File: rtl/mips32_mem_responder.sv
// mips32_mem_responder: single-ported word memory serving I-fetch and D load/store, one transaction at a time.
// Define MIPS32_MEM_ERR_EN to add i_rsp_err/d_rsp_err for addresses beyond the array.
module mips32_mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 2 ** ADDR_W,
  parameter int WAIT_CYC = 1
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
`ifdef MIPS32_MEM_ERR_EN
  output logic        i_rsp_err,
  output logic        d_rsp_err,
`endif
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic [1:0]          r_starve;
  logic                r_port_d, r_we, r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata, r_i_data, r_d_data, w_rdata;
  logic [31:0]         r_mem [DEPTH];
  logic                w_idle, w_i_pri, w_d_hs, w_i_hs, w_access, w_req_err;

  assign w_idle      = rst_n && r_state == IDLE;
  // Two D grants in a row while I waited hand the next slot to I
  assign w_i_pri     = r_starve == 2'd2 && i_req_valid;
  assign d_req_ready = w_idle && !w_i_pri;
  assign i_req_ready = w_idle && (w_i_pri || !d_req_valid);
  assign w_d_hs      = d_req_valid && d_req_ready;
  assign w_i_hs      = i_req_valid && i_req_ready;
  assign w_access    = r_state == WAIT && r_cnt == 4'd0;
  assign w_rdata     = r_err ? '0 : r_mem[r_addr];
  assign busy        = r_state != IDLE;
  assign i_rsp_valid = r_state == RESP && !r_port_d;
  assign d_rsp_valid = r_state == RESP && r_port_d;
  assign i_rsp_data  = r_i_data;
  assign d_rsp_rdata = r_d_data;

`ifdef MIPS32_MEM_ERR_EN
  assign w_req_err = w_d_hs ? |d_req_addr[31:ADDR_W] : |i_req_addr[31:ADDR_W];
  assign i_rsp_err = i_rsp_valid && r_err;
  assign d_rsp_err = d_rsp_valid && r_err;
`else
  logic w_unused;
  assign w_req_err = 1'b0;
  assign w_unused  = ^{i_req_addr[31:ADDR_W], d_req_addr[31:ADDR_W]};
`endif

  always_comb begin
    w_next = r_state == IDLE ? ((w_d_hs || w_i_hs) ? WAIT : IDLE) :
             r_state == WAIT ? (w_access ? RESP : WAIT) : IDLE;
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_starve <= '0;
      r_port_d <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_i_data <= '0;
      r_d_data <= '0;
    end else begin
      if (w_d_hs || w_i_hs) begin
        r_port_d <= w_d_hs;
        r_we     <= w_d_hs && d_req_we;
        r_addr   <= w_d_hs ? d_req_addr[ADDR_W-1:0] : i_req_addr[ADDR_W-1:0];
        r_wdata  <= d_req_wdata;
        r_err    <= w_req_err;
        r_cnt    <= 4'(WAIT_CYC);
        r_starve <= (w_d_hs && i_req_valid) ? r_starve + 2'd1 : 2'd0;
      end
      if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_access && r_port_d) r_d_data <= r_we ? '0 : w_rdata;
      if (w_access && !r_port_d) r_i_data <= w_rdata;
    end
  end

  // A store still in WAIT when reset arrives never reaches the array
  always_ff @(posedge clk1) begin
    if (rst_n && w_access && r_we && !r_err) r_mem[r_addr] <= r_wdata;
  end
endmodule

// File: tb/tb_mips32_mem_responder.sv
// tb_mips32_mem_responder: directed stimulus with a response scoreboard for mips32_mem_responder.
module tb_mips32_mem_responder;
  localparam int WC = 1;
`ifdef MIPS32_MEM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  typedef struct {
    bit          d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    bit          err;
    int          due;
  } exp_t;

  logic        clk1 = 1'b0, rst_n = 1'b0;
  logic        i_req_valid = 1'b1, d_req_valid = 1'b1, d_req_we = 1'b1;
  logic [31:0] i_req_addr = 32'd5, d_req_addr = 32'd5, d_req_wdata = 32'hDEADBEEF;
  logic        i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, busy;
  logic [31:0] i_rsp_data, d_rsp_rdata;
`ifdef MIPS32_MEM_ERR_EN
  logic        i_rsp_err, d_rsp_err;
`endif

  exp_t        q[$];
  exp_t        me;
  bit          grants[$];
  logic [31:0] mdl [1024];
  int          n_cmp = 0, n_bad = 0, cyc = 0;

  mips32_mem_responder #(.ADDR_W(10), .DEPTH(1024), .WAIT_CYC(WC)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
`ifdef MIPS32_MEM_ERR_EN
    .i_rsp_err(i_rsp_err), .d_rsp_err(d_rsp_err),
`endif
    .busy(busy)
  );

  initial forever #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
    return ERR && a[31:10] != 22'd0;
  endfunction

  // Scoreboard: pops on any response, pushes a model prediction on every handshake
  always @(negedge clk1) begin
    if (i_rsp_valid || d_rsp_valid) begin
      chk("rsp_one_port", 32'(i_rsp_valid && d_rsp_valid), 32'd0);
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: i_rsp_valid=%0b d_rsp_valid=%0b, want none", i_rsp_valid, d_rsp_valid);
      end else begin
        me = q.pop_front();
        chk("rsp_port", 32'(d_rsp_valid), 32'(me.d));
        chk("rsp_data", me.d ? d_rsp_rdata : i_rsp_data, me.data);
        chk("rsp_cycle", 32'(cyc), 32'(me.due));
`ifdef MIPS32_MEM_ERR_EN
        chk("rsp_err", 32'(me.d ? d_rsp_err : i_rsp_err), 32'(me.err));
`endif
        if (me.d && me.we && !me.err) mdl[me.addr[9:0]] = me.wdata;
      end
    end
    if (d_req_valid && d_req_ready) begin
      me.d = 1'b1; me.we = d_req_we; me.addr = d_req_addr; me.wdata = d_req_wdata;
      me.err = addr_err(d_req_addr);
      me.data = (d_req_we || me.err) ? 32'd0 : mdl[d_req_addr[9:0]];
      me.due = cyc + WC + 2;
      q.push_back(me);
      grants.push_back(1'b1);
    end
    if (i_req_valid && i_req_ready) begin
      me.d = 1'b0; me.we = 1'b0; me.addr = i_req_addr; me.wdata = 32'd0;
      me.err = addr_err(i_req_addr);
      me.data = me.err ? 32'd0 : mdl[i_req_addr[9:0]];
      me.due = cyc + WC + 2;
      q.push_back(me);
      grants.push_back(1'b0);
    end
  end

  task automatic wait_grants(input int target);
    for (int k = 0; k < 60; k++) begin
      @(posedge clk1); #1;
      if (grants.size() >= target) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL grant_timeout: got %0d grants, want %0d", grants.size(), target);
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk1);
      if (q.size() == 0 && !busy) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
  endtask

  task automatic d_req(input bit we, input logic [31:0] a, input logic [31:0] wd);
    int base;
    base = grants.size();
    @(posedge clk1); #1;
    d_req_valid = 1'b1; d_req_we = we; d_req_addr = a; d_req_wdata = wd;
    wait_grants(base + 1);
    d_req_valid = 1'b0;
    drain();
  endtask

  initial begin
    int  base;
    bit  ord[6];
    ord = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    // Reset held with both requesters pending
    for (int k = 0; k < 3; k++) begin
      @(negedge clk1);
      chk("rst_i_ready", 32'(i_req_ready), 32'd0);
      chk("rst_d_ready", 32'(d_req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp", 32'(i_rsp_valid || d_rsp_valid), 32'd0);
    end
    @(posedge clk1); #1;
    rst_n = 1'b1;
    wait_grants(1);
    d_req_valid = 1'b0; i_req_valid = 1'b0;
    chk("first_grant_d", 32'(grants[0]), 32'd1);
    drain();
    // Load back the stored word
    d_req(1'b0, 32'd5, 32'd0);
    d_req(1'b1, 32'd8, 32'h8888_0008);
    d_req(1'b1, 32'd0, 32'h0000_A0A0);
    // Simultaneous I and D: D first, then I
    base = grants.size();
    @(posedge clk1); #1;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'd8;
    i_req_valid = 1'b1; i_req_addr = 32'd0;
    wait_grants(base + 1);
    d_req_valid = 1'b0;
    wait_grants(base + 2);
    i_req_valid = 1'b0;
    drain();
    chk("pair_first_d", 32'(grants[base]), 32'd1);
    chk("pair_then_i", 32'(grants[base+1]), 32'd0);
    // Continuous contention exercises the anti-starvation slot
    base = grants.size();
    @(posedge clk1); #1;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'd9; d_req_wdata = 32'h99;
    i_req_valid = 1'b1; i_req_addr = 32'd0;
    wait_grants(base + 6);
    d_req_valid = 1'b0; i_req_valid = 1'b0;
    drain();
    for (int k = 0; k < 6; k++) chk($sformatf("grant_order_%0d", k), 32'(grants[base+k]), 32'(ord[k]));
    // Reset during WAIT drops an uncommitted store
    d_req(1'b1, 32'd7, 32'h0BAD_0007);
    base = grants.size();
    @(posedge clk1); #1;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'd7; d_req_wdata = 32'h1234;
    wait_grants(base + 1);
    d_req_valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk1); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk1);
    d_req(1'b0, 32'd7, 32'd0);
    // Out-of-range address: error with ERR_EN, aliases to word 0 without
    d_req(1'b1, 32'h400, 32'h5555_AAAA);
    d_req(1'b0, 32'd0, 32'd0);
    d_req(1'b0, 32'h400, 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
